// File: rtl/data_memory_ctrl_if.sv
// Request/response/debug bundle for data_memory_ctrl.
// Optional access counters are present when DMEM_ACCESS_COUNT_EN is defined.
//
// Handshake: a request transfers on a rising clk edge where i_req_valid and
// o_req_ready are both 1; the master holds the request fields stable while
// i_req_valid is high and not yet accepted. o_rsp_valid is a one-cycle pulse
// that cannot be stalled; o_rdata/o_err are meaningful only during it.
interface data_memory_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_we;
    logic [1:0]            i_size;
    logic                  i_unsigned;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_err;
    logic [ADDR_WIDTH-1:0] i_dbg_addr;
    logic [DATA_WIDTH-1:0] o_dbg_data;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0]           o_load_count;
    logic [31:0]           o_store_count;
    logic [31:0]           o_err_count;
`endif

    modport master (
        output i_req_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_dbg_addr,
`ifdef DMEM_ACCESS_COUNT_EN
        input  o_load_count, o_store_count, o_err_count,
`endif
        input  o_req_ready, o_rsp_valid, o_rdata, o_err, o_dbg_data
    );

    modport slave (
        input  i_req_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_dbg_addr,
`ifdef DMEM_ACCESS_COUNT_EN
        output o_load_count, o_store_count, o_err_count,
`endif
        output o_req_ready, o_rsp_valid, o_rdata, o_err, o_dbg_data
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Handshaked, byte-addressed little-endian data memory for the MEM stage.
// Byte/half/word (and doubleword on 64-bit builds) loads and stores with
// sign/zero extension, alignment/range error reporting, a configurable
// response latency and an independent one-cycle debug read port.
// Optional feature macro: DMEM_ACCESS_COUNT_EN (load/store/error counters).
module data_memory_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_BYTES    = 256,
    parameter int ADDR_WIDTH   = $clog2(MEM_BYTES),
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    data_memory_ctrl_if.slave   bus,
    output logic [1:0]          o_fsm_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam bit LAT_ONE        = (READ_LATENCY == 1);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            mem_q [MEM_BYTES];
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_err_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dbg_q;

    logic                  accept;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [1:0]            op_size;
    logic                  op_we;
    logic                  op_uns;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [31:0]           op_nbytes;
    logic [31:0]           op_addr32;
    logic                  op_err;
    logic [63:0]           wdata64;
    logic [63:0]           raw;
    logic [63:0]           ext;
    logic                  sign_fill;
    logic [DATA_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0] dbg_base;
    logic [DATA_WIDTH-1:0] dbg_word;

    assign accept     = bus.i_req_valid && (state_q == S_IDLE);
    // The array is touched on the edge that enters RESP: the accept edge
    // itself when latency is 1, otherwise the last WAIT edge.
    assign enter_resp = (accept && LAT_ONE) || (state_q == S_WAIT && cnt_q == 4'd1);

    // Operation fields: live inputs on the accept edge, captured copy afterwards.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_addr  = bus.i_addr;
            op_size  = bus.i_size;
            op_we    = bus.i_we;
            op_uns   = bus.i_unsigned;
            op_wdata = bus.i_wdata;
        end else begin
            op_addr  = addr_q;
            op_size  = size_q;
            op_we    = we_q;
            op_uns   = uns_q;
            op_wdata = wdata_q;
        end
    end

    // Error detection, little-endian byte assembly and extension of load data.
    always_comb begin
        op_nbytes = 32'd1 << op_size;
        op_addr32 = 32'(op_addr);
        op_err    = 1'b0;
        if (op_size == 2'b11 && DATA_WIDTH == 32) op_err = 1'b1;
        if ((op_addr32 & (op_nbytes - 32'd1)) != 32'd0) op_err = 1'b1;
        if (op_addr32 + op_nbytes > 32'(MEM_BYTES)) op_err = 1'b1;

        wdata64 = 64'(op_wdata);
        raw     = '0;
        for (int k = 0; k < 8; k++) begin
            if (32'(k) < op_nbytes) raw[8*k +: 8] = mem_q[op_addr + ADDR_WIDTH'(k)];
        end

        sign_fill = 1'b0;
        ext       = '0;
        case (op_size)
            2'b00: begin
                sign_fill = raw[7] && !op_uns;
                ext       = {{56{sign_fill}}, raw[7:0]};
            end
            2'b01: begin
                sign_fill = raw[15] && !op_uns;
                ext       = {{48{sign_fill}}, raw[15:0]};
            end
            2'b10: begin
                sign_fill = raw[31] && !op_uns;
                ext       = {{32{sign_fill}}, raw[31:0]};
            end
            default: ext = raw;
        endcase
        load_data = DATA_WIDTH'(ext);
    end

    // Debug read address is forced to a word boundary.
    always_comb begin
        dbg_base = bus.i_dbg_addr & ~ADDR_WIDTH'(BYTES_PER_WORD - 1);
        dbg_word = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            dbg_word[8*k +: 8] = mem_q[dbg_base + ADDR_WIDTH'(k)];
        end
    end

    // Request FSM: capture on accept, count latency, emit the registered response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            result_q     <= '0;
            result_err_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if (enter_resp) begin
                result_q     <= (op_we || op_err) ? '0 : load_data;
                result_err_q <= op_err;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.i_addr;
                        size_q  <= bus.i_size;
                        we_q    <= bus.i_we;
                        uns_q   <= bus.i_unsigned;
                        wdata_q <= bus.i_wdata;
                        if (LAT_ONE) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(READ_LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= result_q;
                    err_q       <= result_err_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte array: cleared on reset, written only by a legal store entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
        end else if (enter_resp && op_we && !op_err) begin
            for (int k = 0; k < 8; k++) begin
                if (32'(k) < op_nbytes) mem_q[op_addr + ADDR_WIDTH'(k)] <= wdata64[8*k +: 8];
            end
        end
    end

    // Debug port samples the array as it stood before this edge's store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_q <= '0;
        else        dbg_q <= dbg_word;
    end

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;
    logic [31:0] err_cnt_q;

    // Saturating per-class access counters, bumped by each response pulse;
    // we_q still holds the responding request's direction during the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (rsp_valid_q) begin
            if (err_q) begin
                if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
            end else if (we_q) begin
                if (store_cnt_q != 32'hFFFF_FFFF) store_cnt_q <= store_cnt_q + 32'd1;
            end else begin
                if (load_cnt_q != 32'hFFFF_FFFF) load_cnt_q <= load_cnt_q + 32'd1;
            end
        end
    end

    assign bus.o_load_count  = load_cnt_q;
    assign bus.o_store_count = store_cnt_q;
    assign bus.o_err_count   = err_cnt_q;
`endif

    assign bus.o_req_ready = (state_q == S_IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_err       = err_q;
    assign bus.o_dbg_data  = dbg_q;
    assign o_fsm_state     = state_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance at latency 1, one at latency 4.
// A byte-array reference model predicts every response; monitors compare
// responses against the expected queues independently of the drivers.
module tb_data_memory_ctrl;
    localparam int DW = 32;
    localparam int MB = 256;
    localparam int AW = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    logic [1:0] st0;
    logic [1:0] st1;

    data_memory_ctrl #(.DATA_WIDTH(DW), .MEM_BYTES(MB), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .o_fsm_state(st0)
    );
    data_memory_ctrl #(.DATA_WIDTH(DW), .MEM_BYTES(MB), .READ_LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .o_fsm_state(st1)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]    mdl [2][MB];
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    int            acc_q0[$];
    int            acc_q1[$];
    int            cnt_ld[2];
    int            cnt_st[2];
    int            cnt_er[2];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < MB; i++) mdl[d][i] = 8'h00;
            cnt_ld[d] = 0;
            cnt_st[d] = 0;
            cnt_er[d] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
        acc_q0.delete();
        acc_q1.delete();
    endtask

    // Behavioural access: returns {err, rdata} and updates the model array.
    task automatic model_access(input int d, input logic we, input logic [1:0] sz, input logic uns,
                                input int a, input logic [DW-1:0] wd, output logic [DW:0] res);
        int          nb;
        logic [63:0] v;
        nb = 1 << sz;
        if ((sz == 2'd3 && DW == 32) || (a % nb != 0) || (a + nb > MB)) begin
            cnt_er[d]++;
            res = {1'b1, {DW{1'b0}}};
        end else if (we) begin
            cnt_st[d]++;
            for (int k = 0; k < nb; k++) mdl[d][a + k] = 8'(wd >> (8 * k));
            res = '0;
        end else begin
            cnt_ld[d]++;
            v = 64'd0;
            for (int k = 0; k < nb; k++) v = v + (64'(mdl[d][a + k]) << (8 * k));
            if (!uns && v[8 * nb - 1]) v = v | (~64'd0 << (8 * nb));
            res = {1'b0, DW'(v)};
        end
    endtask

    function automatic logic [DW-1:0] model_word(input int d, input int a);
        logic [DW-1:0] w;
        int            base;
        w    = '0;
        base = a - (a % (DW / 8));
        for (int k = 0; k < DW / 8; k++) w = w | (DW'(mdl[d][base + k]) << (8 * k));
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int d, input logic v, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (d == 0) begin
            bus0.i_req_valid = v; bus0.i_we = we; bus0.i_size = sz;
            bus0.i_unsigned = uns; bus0.i_addr = a; bus0.i_wdata = wd;
        end else begin
            bus1.i_req_valid = v; bus1.i_we = we; bus1.i_size = sz;
            bus1.i_unsigned = uns; bus1.i_addr = a; bus1.i_wdata = wd;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus0.o_req_ready : bus1.o_req_ready;
    endfunction

    // Present one request, wait (bounded) for acceptance, push the prediction.
    task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, output int acc_cyc);
        logic [DW:0] res;
        int          n;
        n = 0;
        set_req(d, 1'b1, we, sz, uns, a, wd);
        while (!get_ready(d) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_in_time", 64'(n < 64), 64'd1);
        acc_cyc = -1;
        if (n < 64) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
            model_access(d, we, sz, uns, int'(a), wd, res);
            if (d == 0) begin exp_q0.push_back(res); acc_q0.push_back(acc_cyc); end
            else        begin exp_q1.push_back(res); acc_q1.push_back(acc_cyc); end
            check("ready_low_after_accept", 64'(get_ready(d)), 64'd0);
        end
        set_req(d, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", 64'(n < 100), 64'd1);
    endtask

    // ---------------- monitors ----------------
    task automatic mon(input int d);
        logic          v;
        logic          e;
        logic [DW-1:0] r;
        logic [DW:0]   x;
        int            ac;
        v = (d == 0) ? bus0.o_rsp_valid : bus1.o_rsp_valid;
        e = (d == 0) ? bus0.o_err       : bus1.o_err;
        r = (d == 0) ? bus0.o_rdata     : bus1.o_rdata;
        if (!rst_n) return;
        if (v) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                check("rsp_unexpected", 64'(v), 64'd0);
            end else begin
                if (d == 0) begin x = exp_q0.pop_front(); ac = acc_q0.pop_front(); end
                else        begin x = exp_q1.pop_front(); ac = acc_q1.pop_front(); end
                check("rsp_rdata", 64'(r), 64'(x[DW-1:0]));
                check("rsp_err", 64'(e), 64'(x[DW]));
                check("rsp_latency", 64'(cyc - ac), 64'(lat(d)));
            end
        end else begin
            check("idle_rdata_err_zero", 64'({e, r}), 64'd0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int            a;
        int            prev;
        int            d;
        int            nb;
        logic [1:0]    sz;
        logic [AW-1:0] ad;

        set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
        bus0.i_dbg_addr = '0;
        bus1.i_dbg_addr = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("reset_state0", 64'(st0), 64'd0);
        check("reset_state1", 64'(st1), 64'd0);
        check("reset_ready0", 64'(bus0.o_req_ready), 64'd1);
        check("reset_rsp1", 64'({bus1.o_rsp_valid, bus1.o_err, bus1.o_rdata}), 64'd0);
        check("reset_dbg0", 64'(bus0.o_dbg_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed latency-1 sequence.
        issue(0, 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, a);
        issue(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, a);
        issue(0, 1'b0, 2'd0, 1'b0, 8'h13, 32'h0, a);
        issue(0, 1'b0, 2'd0, 1'b1, 8'h13, 32'h0, a);
        issue(0, 1'b0, 2'd1, 1'b0, 8'h10, 32'h0, a);
        issue(0, 1'b1, 2'd1, 1'b0, 8'h11, 32'h1234, a);
        issue(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, a);
        issue(0, 1'b0, 2'd2, 1'b0, 8'hFC, 32'h0, a);
        issue(0, 1'b0, 2'd1, 1'b0, 8'hFF, 32'h0, a);
        issue(0, 1'b0, 2'd3, 1'b0, 8'h00, 32'h0, a);
        drain();

        // Back-to-back loads on the latency-4 instance: accepts 5 cycles apart.
        issue(1, 1'b1, 2'd2, 1'b0, 8'h40, 32'h8765_4321, prev);
        for (int i = 0; i < 6; i++) begin
            issue(1, 1'b0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'h40, 32'h0, a);
            check("b2b_accept_spacing", 64'(a - prev), 64'd5);
            prev = a;
        end
        drain();

        // Randomized mix on both instances.
        for (int i = 0; i < 160; i++) begin
            d  = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            a  = $urandom_range(0, MB - 1);
            if ($urandom_range(0, 3) != 0) a = a - (a % nb);
            ad = AW'(a);
            issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, DW'($urandom), a);
        end
        drain();

        // Debug port reads at rest.
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, MB - 1);
            bus0.i_dbg_addr = AW'(a);
            bus1.i_dbg_addr = AW'(a);
            @(posedge clk); #1;
            check("dbg_word0", 64'(bus0.o_dbg_data), 64'(model_word(0, a)));
            check("dbg_word1", 64'(bus1.o_dbg_data), 64'(model_word(1, a)));
        end

`ifdef DMEM_ACCESS_COUNT_EN
        @(posedge clk); #1;
        check("load_count0", 64'(bus0.o_load_count), 64'(cnt_ld[0]));
        check("store_count0", 64'(bus0.o_store_count), 64'(cnt_st[0]));
        check("err_count0", 64'(bus0.o_err_count), 64'(cnt_er[0]));
        check("load_count1", 64'(bus1.o_load_count), 64'(cnt_ld[1]));
        check("store_count1", 64'(bus1.o_store_count), 64'(cnt_st[1]));
        check("err_count1", 64'(bus1.o_err_count), 64'(cnt_er[1]));
`endif

        // Reset in WAIT during a byte store: nothing of it may survive.
        issue(1, 1'b1, 2'd2, 1'b0, 8'h20, 32'h1122_3344, a);
        drain();
        bus1.i_dbg_addr = 8'h20;
        @(posedge clk); #1;
        check("dbg_before_reset", 64'(bus1.o_dbg_data), 64'(model_word(1, 32)));
        issue(1, 1'b1, 2'd0, 1'b0, 8'h20, 32'h0000_00A5, a);
        @(posedge clk); #1;
        check("in_wait_state", 64'(st1), 64'd1);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_rsp_valid", 64'(bus1.o_rsp_valid), 64'd0);
        check("rst_rdata_err", 64'({bus1.o_err, bus1.o_rdata}), 64'd0);
        check("rst_dbg", 64'(bus1.o_dbg_data), 64'd0);
        check("rst_state", 64'(st1), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_dbg_0x20", 64'(bus1.o_dbg_data), 64'(model_word(1, 32)));
        check("post_rst_ready", 64'(bus1.o_req_ready), 64'd1);
        issue(1, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, a);
        issue(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, a);
        drain();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, handshaked data memory for the MIPS MEM stage.
- Byte-addressed, little-endian array with configurable data width, depth and read latency.
- Supports byte/half/word (and doubleword at 64-bit) loads and stores, with sign/zero extension and alignment/range error detection.
- Adds a 1-cycle synchronous debug read port used by the debug unit.

Parameters:
- DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- MEM_BYTES, 256, memory size in bytes; power of two, at least DATA_WIDTH/8.
- ADDR_WIDTH, $clog2(MEM_BYTES), byte address width.
- READ_LATENCY, 1, cycles from request accept to response; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  controller can accept a request.
- i_we  in  1  1 = store, 0 = load.
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword (64-bit builds only).
- i_unsigned  in  1  load: 1 = zero-extend, 0 = sign-extend.
- i_addr  in  ADDR_WIDTH  byte address.
- i_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rdata  out  DATA_WIDTH  extended load data.
- o_err  out  1  qualifies o_rsp_valid; access misaligned, out of range or illegal size.
- i_dbg_addr  in  ADDR_WIDTH  debug byte address.
- o_dbg_data  out  DATA_WIDTH  debug read data.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-low.
  - On reset, state = IDLE, the whole array is cleared to 0, and o_rsp_valid, o_rdata, o_err and o_dbg_data are all 0.
  - Reset asserted mid-operation aborts the access; no partial write may remain after reset.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
  - o_req_ready is 1 only in IDLE.
  - A request is accepted on a rising edge where i_req_valid & o_req_ready. At accept, addr, size, we, unsigned and wdata are captured.
  - After accept: if READ_LATENCY = 1, go directly to RESP; otherwise go to WAIT with latency counter = READ_LATENCY-1.
  - WAIT decrements the counter each cycle and moves to RESP when the counter reaches 1.
- Timing:
  - Request accepted at edge N -> o_rsp_valid is high for exactly the cycle after edge N+READ_LATENCY.
  - Throughput is 1 request per READ_LATENCY+1 cycles.
- Memory access:
  - The array is read or written on the edge that enters RESP.
  - Stores write exactly 2^size bytes starting at addr (little-endian: byte k of wdata goes to addr+k). o_rdata = 0 for stores.
  - Loads assemble 2^size bytes, then zero- or sign-extend them to DATA_WIDTH.
  - A word load on a 64-bit build extends from bit 31.
- Errors:
  - o_err = 1 if any of the following holds:
    - size = 11 and DATA_WIDTH = 32;
    - addr is not a multiple of 2^size;
    - addr + 2^size > MEM_BYTES.
  - An erroring access performs no memory write, returns o_rdata = 0, and still takes full latency.
- Response outputs:
  - o_rdata and o_err are valid only while o_rsp_valid = 1; outside that cycle they hold 0.
  - The response cannot be back-pressured.
- Debug port:
  - Every rising edge, o_dbg_data <= the full DATA_WIDTH word at i_dbg_addr with the low $clog2(DATA_WIDTH/8) bits forced to 0.
  - Reads the array state before any same-edge store.
  - Runs independently of the FSM.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs o_load_count (32), o_store_count (32) and o_err_count (32).
  - Each counter increments on the o_rsp_valid cycle of the matching access. An errored access increments only o_err_count.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- READ_LATENCY=1: store word 0xDEADBEEF at 0x10, then load word from 0x10 -> o_rsp_valid 1 cycle after each accept; o_rdata = 0xDEADBEEF; o_err = 0.
- After the above store: load byte signed from 0x13 -> 0xFFFFFFDE; load byte unsigned from 0x13 -> 0x000000DE; load half signed from 0x10 -> 0xFFFFBEEF.
- Store half 0x1234 to 0x11 -> o_err = 1 and the array is unchanged; load word from 0xFC with MEM_BYTES=256 succeeds; load word from 0x100 is impossible by width, and load half from 0xFF -> o_err = 1.
- READ_LATENCY=4: hold i_req_valid high with back-to-back loads -> o_req_ready low for 4 cycles after each accept; o_rsp_valid 4 cycles after each accept; accepts spaced exactly 5 cycles apart.
- Deassert rst_n in WAIT during a store of 0xA5 to 0x20 -> outputs 0 immediately; after release, o_dbg_data at 0x20 = 0 and o_req_ready = 1.
- With DMEM_ACCESS_COUNT_EN: 3 loads, 2 stores, 1 misaligned load -> counts 3/2/1.
